// File: rtl/uart_rx.sv
// Single-character asynchronous UART receiver on a 16x baud clock enable, for the DZ11 line path.
// Define UARTRX_MAJORITY_EN to take every bit as a 2-of-3 vote of the samples at brdiv=2,1,0.
module uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] length,
  input  logic [1:0] parity,
  input  logic       brgCLKEN,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       full,
  output logic       intr,
  output logic       perr,
  output logic       ferr,
  output logic       ovre
);

  localparam logic [1:0] ParEven = 2'd1;
  localparam logic [1:0] ParOdd  = 2'd2;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StBit0,
    StBit1,
    StBit2,
    StBit3,
    StBit4,
    StBit5,
    StBit6,
    StBit7,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] brdiv_q, brdiv_d;
  logic [7:0] shreg_q, shreg_d;
  logic       perr_nx_q, perr_nx_d;
  logic       ferr_nx_q, ferr_nx_d;
  logic [7:0] data_q, data_d;
  logic       full_q, full_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovre_q, ovre_d;
  logic [1:0] sync_q, sync_d;
  logic       rxp_q, rxp_d;

  logic       rxs;
  logic       sample;
  logic       sample_tick;
  logic       parity_en;
  logic [2:0] bit_idx;
  logic       last_bit;

  assign rxs         = sync_q[1];
  assign sample_tick = brgCLKEN && (brdiv_q == 4'd0);
  assign parity_en   = (parity == ParEven) || (parity == ParOdd);
  assign bit_idx     = 3'(4'(state_q) - 4'(StBit0));
  // The last data bit index is 4 + length, i.e. {1, length}.
  assign last_bit    = (bit_idx == {1'b1, length});

`ifdef UARTRX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b00;
    end else if (clr) begin
      hist_q <= 2'b00;
    end else if (brgCLKEN) begin
      hist_q <= {hist_q[0], rxs};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign sample = rxs;
`endif

  always_comb begin
    state_d   = state_q;
    brdiv_d   = brdiv_q;
    shreg_d   = shreg_q;
    perr_nx_d = perr_nx_q;
    ferr_nx_d = ferr_nx_q;
    data_d    = data_q;
    full_d    = full_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovre_d    = ovre_q;
    sync_d    = {sync_q[0], rxd};
    rxp_d     = brgCLKEN ? rxs : rxp_q;
    intr      = 1'b0;

    // A read in the DONE clock is overridden below so the new character is kept.
    if (rd) begin
      full_d = 1'b0;
    end
    if (brgCLKEN && (brdiv_q != 4'd0)) begin
      brdiv_d = brdiv_q - 4'd1;
    end

    case (state_q)
      StIdle: begin
        if (brgCLKEN && rxp_q && !rxs) begin
          brdiv_d   = 4'd7;
          shreg_d   = 8'h00;
          perr_nx_d = 1'b0;
          ferr_nx_d = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (sample_tick) begin
          if (sample) begin
            state_d = StIdle;
          end else begin
            brdiv_d = 4'd15;
            state_d = StBit0;
          end
        end
      end
      StBit0, StBit1, StBit2, StBit3, StBit4, StBit5, StBit6, StBit7: begin
        if (sample_tick) begin
          shreg_d[bit_idx] = sample;
          brdiv_d          = 4'd15;
          if (last_bit) begin
            state_d = parity_en ? StParity : StStop;
          end else begin
            state_d = state_e'(4'(state_q) + 4'd1);
          end
        end
      end
      StParity: begin
        if (sample_tick) begin
          // Unused high bits of shreg are zero, so the full-width XOR is the data parity.
          perr_nx_d = (parity == ParOdd) ? ((^shreg_q) == sample) : ((^shreg_q) != sample);
          brdiv_d   = 4'd15;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (sample_tick) begin
          ferr_nx_d = ~sample;
          state_d   = StDone;
        end
      end
      StDone: begin
        intr    = 1'b1;
        data_d  = shreg_q;
        perr_d  = perr_nx_q;
        ferr_d  = ferr_nx_q;
        ovre_d  = full_q & ~rd;
        full_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (clr) begin
      state_d   = StIdle;
      brdiv_d   = 4'd0;
      shreg_d   = 8'h00;
      perr_nx_d = 1'b0;
      ferr_nx_d = 1'b0;
      data_d    = 8'h00;
      full_d    = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      ovre_d    = 1'b0;
      sync_d    = 2'b00;
      rxp_d     = 1'b0;
      intr      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      brdiv_q   <= 4'd0;
      shreg_q   <= 8'h00;
      perr_nx_q <= 1'b0;
      ferr_nx_q <= 1'b0;
      data_q    <= 8'h00;
      full_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovre_q    <= 1'b0;
      sync_q    <= 2'b00;
      rxp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      brdiv_q   <= brdiv_d;
      shreg_q   <= shreg_d;
      perr_nx_q <= perr_nx_d;
      ferr_nx_q <= ferr_nx_d;
      data_q    <= data_d;
      full_q    <= full_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovre_q    <= ovre_d;
      sync_q    <= sync_d;
      rxp_q     <= rxp_d;
    end
  end

  assign data = data_q;
  assign full = full_q;
  assign perr = perr_q;
  assign ferr = ferr_q;
  assign ovre = ovre_q;

endmodule
